// File: rtl/scie_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scie_pkg
// Brief    : Shared opcode, FSM state type and request record for the SCIE
//            issue queue.
// Revision : 1.0
// ============================================================================
package scie_pkg;

  localparam logic [6:0] SCIE_OPCODE = 7'h7B;
  localparam int         SCIE_XLEN   = 32;
  localparam int         SCIE_TAG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } scie_state_e;

  typedef struct packed {
    logic [31:0]            insn;
    logic [SCIE_XLEN-1:0]   rs1;
    logic [SCIE_XLEN-1:0]   rs2;
    logic [SCIE_TAG_W-1:0]  tag;
  } scie_req_t;

  function automatic logic is_custom3(input logic [6:0] opcode);
    return opcode == SCIE_OPCODE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scie_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : scie_req_fifo
// Brief    : DEPTH-entry request FIFO; head is read straight from the storage
//            registers and forced to zero while empty.
// Revision : 1.0
// ============================================================================
module scie_req_fifo
  import scie_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  scie_req_t push_data,
  input  logic      pop,
  output scie_req_t head,
  output logic      full,
  output logic      empty
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  scie_req_t          r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  // Flags come only from the registered count, so ready never sees a same-cycle pop.
  assign full   = (r_count == c_depth);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/scie_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : scie_issue_queue
// Brief    : Queues custom-3 requests, feeds the head to the single-cycle SCIE
//            datapath and returns tagged results over valid/ready.
//            Optional SCIE_PERF_CNT_EN adds op/illegal completion counters.
// Revision : 1.0
// ============================================================================
module scie_issue_queue
  import scie_pkg::*;
#(
  parameter int XLEN  = SCIE_XLEN,
  parameter int DEPTH = 4,
  parameter int TAG_W = SCIE_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [31:0]      io_req_insn,
  input  logic [XLEN-1:0]  io_req_rs1,
  input  logic [XLEN-1:0]  io_req_rs2,
  input  logic [TAG_W-1:0] io_req_tag,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [XLEN-1:0]  io_resp_rd,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic             io_resp_illegal,
  output logic [31:0]      scie_insn,
  output logic [XLEN-1:0]  scie_rs1,
  output logic [XLEN-1:0]  scie_rs2,
  input  logic [XLEN-1:0]  scie_rd,
  output logic             io_busy
`ifdef SCIE_PERF_CNT_EN
  ,
  output logic [31:0]      io_perf_ops,
  output logic [31:0]      io_perf_illegal
`endif
);

  scie_state_e      r_state;
  scie_state_e      w_state_nxt;
  scie_req_t        w_push_data;
  scie_req_t        w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_resp_fire;
  logic [XLEN-1:0]  r_resp_rd;
  logic [TAG_W-1:0] r_resp_tag;
  logic             r_resp_illegal;

  assign w_push_data = '{insn: io_req_insn, rs1: io_req_rs1, rs2: io_req_rs2, tag: io_req_tag};
  assign io_req_ready = !w_full;
  assign w_push       = io_req_valid && io_req_ready;
  assign w_resp_fire  = io_resp_valid && io_resp_ready;

  scie_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign scie_insn = w_head.insn;
  assign scie_rs1  = w_head.rs1;
  assign scie_rs2  = w_head.rs2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) w_state_nxt = EXEC;
      EXEC: begin
        w_pop       = 1'b1;
        w_state_nxt = RESP;
      end
      // A push landing on the handshake edge is enough to keep issuing.
      RESP: if (io_resp_ready) w_state_nxt = (!w_empty || w_push) ? EXEC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_resp_rd      <= '0;
      r_resp_tag     <= '0;
      r_resp_illegal <= 1'b0;
    end else if (r_state == EXEC) begin
      r_resp_rd      <= is_custom3(w_head.insn[6:0]) ? scie_rd : '0;
      r_resp_tag     <= w_head.tag;
      r_resp_illegal <= !is_custom3(w_head.insn[6:0]);
    end
  end

  assign io_resp_valid   = (r_state == RESP);
  assign io_resp_rd      = r_resp_rd;
  assign io_resp_tag     = r_resp_tag;
  assign io_resp_illegal = r_resp_illegal;
  assign io_busy         = !w_empty || (r_state != IDLE);

`ifdef SCIE_PERF_CNT_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_illegal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_ops     <= '0;
      r_perf_illegal <= '0;
    end else if (w_resp_fire) begin
      r_perf_ops <= r_perf_ops + 32'd1;
      if (r_resp_illegal) r_perf_illegal <= r_perf_illegal + 32'd1;
    end
  end

  assign io_perf_ops     = r_perf_ops;
  assign io_perf_illegal = r_perf_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scie_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_scie_issue_queue
// Brief    : Self-checking bench: directed cases plus random traffic scored
//            against an in-order result queue and a behavioural SCIE model.
// Revision : 1.0
// ============================================================================
module tb_scie_issue_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clock         = 1'b0;
  logic             reset         = 1'b0;
  logic             io_req_valid  = 1'b0;
  logic             io_req_ready;
  logic [31:0]      io_req_insn   = '0;
  logic [XLEN-1:0]  io_req_rs1    = '0;
  logic [XLEN-1:0]  io_req_rs2    = '0;
  logic [TAG_W-1:0] io_req_tag    = '0;
  logic             io_resp_valid;
  logic             io_resp_ready = 1'b0;
  logic [XLEN-1:0]  io_resp_rd;
  logic [TAG_W-1:0] io_resp_tag;
  logic             io_resp_illegal;
  logic [31:0]      scie_insn;
  logic [XLEN-1:0]  scie_rs1;
  logic [XLEN-1:0]  scie_rs2;
  logic [XLEN-1:0]  scie_rd;
  logic             io_busy;
`ifdef SCIE_PERF_CNT_EN
  logic [31:0]      io_perf_ops;
  logic [31:0]      io_perf_illegal;
`endif

  always #5 clock = ~clock;

  scie_issue_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_req_valid    (io_req_valid),
    .io_req_ready    (io_req_ready),
    .io_req_insn     (io_req_insn),
    .io_req_rs1      (io_req_rs1),
    .io_req_rs2      (io_req_rs2),
    .io_req_tag      (io_req_tag),
    .io_resp_valid   (io_resp_valid),
    .io_resp_ready   (io_resp_ready),
    .io_resp_rd      (io_resp_rd),
    .io_resp_tag     (io_resp_tag),
    .io_resp_illegal (io_resp_illegal),
    .scie_insn       (scie_insn),
    .scie_rs1        (scie_rs1),
    .scie_rs2        (scie_rs2),
    .scie_rd         (scie_rd),
    .io_busy         (io_busy)
`ifdef SCIE_PERF_CNT_EN
    ,
    .io_perf_ops     (io_perf_ops),
    .io_perf_illegal (io_perf_illegal)
`endif
  );

  // Stand-in SCIE unit: clamp rs1 at zero, and at rs2 when rs2 is non-zero.
  function automatic logic [XLEN-1:0] scie_ref(input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
    if ($signed(rs1) < 0) return '0;
    if (rs2 != '0 && rs1 > rs2) return rs2;
    return rs1;
  endfunction

  assign scie_rd = scie_ref(scie_rs1, scie_rs2);

  typedef struct {
    logic [XLEN-1:0]  rd;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } exp_t;

  exp_t             exp_q[$];
  int               outstanding = 0;
  int               checks      = 0;
  int               failures    = 0;
  bit               hold_v      = 1'b0;
  logic [XLEN-1:0]  hold_rd;
  logic [TAG_W-1:0] hold_tag;
  logic             hold_illegal;
  logic [31:0]      rnd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: score everything the coming edge will do, then step past it.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    check("busy", io_busy, outstanding != 0);
    if (outstanding < DEPTH)      check("req_ready_open", io_req_ready, 1);
    else if (outstanding > DEPTH) check("req_ready_full", io_req_ready, 0);
    if (hold_v) begin
      check("hold_valid", io_resp_valid, 1);
      check("hold_rd", io_resp_rd, hold_rd);
      check("hold_tag", io_resp_tag, hold_tag);
      check("hold_illegal", io_resp_illegal, hold_illegal);
    end
    hold_v       = io_resp_valid && !io_resp_ready;
    hold_rd      = io_resp_rd;
    hold_tag     = io_resp_tag;
    hold_illegal = io_resp_illegal;
    if (io_resp_valid && io_resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_spurious", io_resp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rd", io_resp_rd, e.rd);
        check("resp_tag", io_resp_tag, e.tag);
        check("resp_illegal", io_resp_illegal, e.illegal);
        outstanding--;
      end
    end
    if (io_req_valid && io_req_ready) begin
      e.illegal = (io_req_insn[6:0] != 7'h7B);
      e.rd      = e.illegal ? '0 : scie_ref(io_req_rs1, io_req_rs2);
      e.tag     = io_req_tag;
      exp_q.push_back(e);
      outstanding++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] insn, input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                      input logic [TAG_W-1:0] tag);
    io_req_insn  = insn;
    io_req_rs1   = rs1;
    io_req_rs2   = rs2;
    io_req_tag   = tag;
    io_req_valid = 1'b1;
    tick();
    io_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    io_req_valid  = 1'b0;
    io_resp_ready = 1'b1;
    while (outstanding != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_done", outstanding, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    check("rst_resp_valid", io_resp_valid, 0);
    check("rst_req_ready", io_req_ready, 1);
    check("rst_busy", io_busy, 0);
    check("rst_resp_rd", io_resp_rd, 0);
    check("rst_scie_insn", scie_insn, 0);
    #10 reset = 1'b1;
    @(posedge clock);
    #1;

    // Latency of a single legal request
    io_resp_ready = 1'b1;
    send(32'h0000_007B, 32'd8192, 32'd0, 5'd3);
    check("lat_edge1_valid", io_resp_valid, 0);
    tick();
    check("lat_edge2_valid", io_resp_valid, 0);
    tick();
    check("lat_valid", io_resp_valid, 1);
    check("lat_rd", io_resp_rd, 32'd8192);
    check("lat_tag", io_resp_tag, 3);
    check("lat_illegal", io_resp_illegal, 0);
    drain();

    // Negative operand clamps to zero
    send(32'h0000_007B, -32'sd7936, 32'd0, 5'd4);
    drain();

    // Illegal opcode then legal
    send(32'h0000_0033, 32'd1792, 32'd0, 5'd7);
    send(32'h0000_007B, 32'd1792, 32'd0, 5'd8);
    drain();

    // Capacity under backpressure
    io_resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      io_req_insn  = 32'h0000_007B;
      io_req_rs1   = XLEN'(100 * (i + 1));
      io_req_rs2   = '0;
      io_req_tag   = TAG_W'(10 + i);
      io_req_valid = 1'b1;
      tick();
    end
    io_req_valid = 1'b0;
    check("cap_accepted", outstanding, 5);
    check("cap_ready_low", io_req_ready, 0);
    drain();

    // Reset with requests queued
    io_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h0000_007B, XLEN'(i + 1), 32'd0, TAG_W'(20 + i));
    tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_resp_valid", io_resp_valid, 0);
    check("mid_rst_req_ready", io_req_ready, 1);
    check("mid_rst_busy", io_busy, 0);
    exp_q.delete();
    outstanding = 0;
    hold_v      = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    io_resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_idle", io_busy, 0);

`ifdef SCIE_PERF_CNT_EN
    check("perf_ops_rst", io_perf_ops, 0);
    check("perf_illegal_rst", io_perf_illegal, 0);
    for (int i = 0; i < 12; i++)
      send((i < 10) ? 32'h0000_007B : 32'h0000_0013, XLEN'(i), 32'd0, TAG_W'(i));
    drain();
    check("perf_ops", io_perf_ops, 12);
    check("perf_illegal", io_perf_illegal, 2);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom();
      if ($urandom_range(0, 3) != 0) rnd[6:0] = 7'h7B;
      io_req_insn   = rnd;
      io_req_rs1    = ($urandom_range(0, 3) == 0) ? -XLEN'($urandom_range(1, 5000)) : XLEN'($urandom_range(0, 20000));
      io_req_rs2    = ($urandom_range(0, 1) == 0) ? '0 : XLEN'($urandom_range(1, 20000));
      io_req_tag    = TAG_W'($urandom());
      io_req_valid  = ($urandom_range(0, 1) == 1);
      io_resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
